// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage next-PC generator: pc_src encodings
// and the default reset / exception addresses.
package pc_gen_pkg;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_JR     = 3'd3,
    PC_RAS    = 3'd4
  } pc_src_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; when full, a push overwrites the oldest entry
// and sets a sticky overflow flag.
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_overflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_doPush;
  logic          w_doReplace;
  logic          w_doPop;
  logic [PW-1:0] w_wrIdx;

  // Push+pop on an empty stack degenerates to a plain push.
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(RAS_DEPTH));
  assign w_doPush    = i_en & i_push & (~i_pop | w_empty);
  assign w_doReplace = i_en & i_push & i_pop & ~w_empty;
  assign w_doPop     = i_en & i_pop & ~i_push & ~w_empty;
  assign w_wrIdx     = w_doPush ? (r_top + PW'(1)) : r_top;

  always_ff @(posedge clk) begin
    if (w_doPush || w_doReplace) begin
      r_mem[w_wrIdx] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_top      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_doPush) begin
      r_top <= r_top + PW'(1);
      if (w_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end else if (w_doPop) begin
      r_top   <= r_top - PW'(1);
      r_count <= r_count - CW'(1);
    end
  end

  assign o_top      = w_empty ? '0 : r_mem[r_top];
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage next-PC generator: PC register, redirect selection, stall-time
// redirect holding, exception vectoring and a return-address stack.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int               RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       pc_src,
  input  logic             cmp,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             link_push,
  input  logic [WIDTH-1:0] link_addr,
  input  logic             ras_pop,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_overflow,
  output logic             pc_misaligned
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pendTarget;
  logic             r_pendValid;

  logic             w_redirect;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_pcPlus4;
  logic [WIDTH-1:0] w_rasTop;
  logic             w_rasEmpty;

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .reset      (reset),
    .i_en       (~stall),
    .i_push     (link_push),
    .i_pop      (ras_pop),
    .i_data     (link_addr),
    .o_top      (w_rasTop),
    .o_empty    (w_rasEmpty),
    .o_overflow (ras_overflow)
  );

  assign w_pcPlus4 = r_pc + WIDTH'(4);

  // A predicted return falls back to the register target when the stack is empty.
  always_comb begin
    w_redirect = 1'b0;
    w_target   = '0;
    case (pc_src)
      PC_BRANCH: begin
        w_redirect = cmp;
        w_target   = branch_target;
      end
      PC_JUMP: begin
        w_redirect = 1'b1;
        w_target   = jump_target;
      end
      PC_JR: begin
        w_redirect = 1'b1;
        w_target   = jr_target;
      end
      PC_RAS: begin
        w_redirect = 1'b1;
        w_target   = w_rasEmpty ? jr_target : w_rasTop;
      end
      default: begin
        w_redirect = 1'b0;
        w_target   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_pendValid  <= 1'b0;
      r_pendTarget <= '0;
    end else if (exc_req) begin
      r_pc        <= EXC_VECTOR;
      r_pendValid <= 1'b0;
    end else if (stall) begin
      if (w_redirect) begin
        r_pendTarget <= w_target;
        r_pendValid  <= 1'b1;
      end
    end else if (r_pendValid) begin
      r_pc        <= r_pendTarget;
      r_pendValid <= 1'b0;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else begin
      r_pc <= w_pcPlus4;
    end
  end

  assign pc            = r_pc;
  assign pc_plus4      = w_pcPlus4;
  assign ras_top       = w_rasTop;
  assign ras_empty     = w_rasEmpty;
  assign pc_misaligned = |r_pc[1:0];

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_pc_gen;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  pc_src;
  logic        cmp;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        link_push;
  logic [31:0] link_addr;
  logic        ras_pop;
  logic        exc_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] ras_top;
  logic        ras_empty;
  logic        ras_overflow;
  logic        pc_misaligned;

  int assertions = 0;
  int failures   = 0;
  bit checkEn    = 0;

  logic [31:0] mPc;
  logic [31:0] mPendTarget;
  bit          mPendValid;
  logic [31:0] mRas[$];
  bit          mOverflow;

  pc_gen dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pc_src        (pc_src),
    .cmp           (cmp),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .link_push     (link_push),
    .link_addr     (link_addr),
    .ras_pop       (ras_pop),
    .exc_req       (exc_req),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .ras_top       (ras_top),
    .ras_empty     (ras_empty),
    .ras_overflow  (ras_overflow),
    .pc_misaligned (pc_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] modelTop();
    return (mRas.size() == 0) ? 32'h0 : mRas[mRas.size()-1];
  endfunction

  task automatic modelReset();
    mPc         = 32'h0000_3000;
    mPendValid  = 0;
    mPendTarget = 32'h0;
    mRas.delete();
    mOverflow   = 0;
  endtask

  // Applies the architectural next-PC and return-stack rules for one edge.
  task automatic modelStep();
    bit          redir;
    logic [31:0] tgt;
    if (reset) begin
      modelReset();
      return;
    end
    redir = 0;
    tgt   = 32'h0;
    if (pc_src == 3'd1 && cmp) begin redir = 1; tgt = branch_target; end
    else if (pc_src == 3'd2) begin redir = 1; tgt = jump_target; end
    else if (pc_src == 3'd3) begin redir = 1; tgt = jr_target; end
    else if (pc_src == 3'd4) begin redir = 1; tgt = (mRas.size() != 0) ? modelTop() : jr_target; end

    if (exc_req) begin
      mPc = 32'h0000_4180;
      mPendValid = 0;
    end else if (stall) begin
      if (redir) begin mPendTarget = tgt; mPendValid = 1; end
    end else if (mPendValid) begin
      mPc = mPendTarget;
      mPendValid = 0;
    end else if (redir) begin
      mPc = tgt;
    end else begin
      mPc = mPc + 32'd4;
    end

    if (!stall) begin
      if (link_push && ras_pop && mRas.size() != 0) begin
        mRas[mRas.size()-1] = link_addr;
      end else if (link_push) begin
        if (mRas.size() == 4) begin
          void'(mRas.pop_front());
          mOverflow = 1;
        end
        mRas.push_back(link_addr);
      end else if (ras_pop && mRas.size() != 0) begin
        void'(mRas.pop_back());
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [2:0] src, input logic c,
                               input logic push, input logic [31:0] la, input logic pop,
                               input logic exc);
    stall = st; pc_src = src; cmp = c; link_push = push; link_addr = la;
    ras_pop = pop; exc_req = exc;
    step();
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("pc", pc, mPc);
      checkOutput("pc_plus4", pc_plus4, mPc + 32'd4);
      checkOutput("ras_top", ras_top, modelTop());
      checkOutput("ras_empty", {31'h0, ras_empty}, {31'h0, mRas.size() == 0});
      checkOutput("ras_overflow", {31'h0, ras_overflow}, {31'h0, mOverflow});
      checkOutput("pc_misaligned", {31'h0, pc_misaligned}, {31'h0, mPc[1:0] != 2'b00});
    end
  end

  initial begin
    reset = 1'b1; stall = 0; pc_src = 0; cmp = 0; branch_target = 0; jump_target = 0;
    jr_target = 0; link_push = 0; link_addr = 0; ras_pop = 0; exc_req = 0;
    modelReset();
    step();
    step();
    reset = 1'b0;
    checkEn = 1;
    checkOutput("reset_pc", pc, 32'h0000_3000);
    checkOutput("reset_empty", {31'h0, ras_empty}, 32'h1);
    checkOutput("reset_top", ras_top, 32'h0);
    checkOutput("reset_ovf", {31'h0, ras_overflow}, 32'h0);

    applyStimulus(0, 3'd0, 0, 0, 0, 0, 0); checkOutput("seq1", pc, 32'h3004);
    applyStimulus(0, 3'd0, 0, 0, 0, 0, 0); checkOutput("seq2", pc, 32'h3008);
    applyStimulus(0, 3'd0, 0, 0, 0, 0, 0); checkOutput("seq3", pc, 32'h300C);

    // Asynchronous reset must take effect before the next clock edge.
    reset = 1'b1;
    #1;
    checkOutput("async_reset", pc, 32'h0000_3000);
    modelReset();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(0, 3'd0, 0, 0, 0, 0, 0);
    checkOutput("seq_3010", pc, 32'h3010);

    branch_target = 32'h3100;
    applyStimulus(0, 3'd1, 0, 0, 0, 0, 0); checkOutput("branch_not_taken", pc, 32'h3014);
    applyStimulus(0, 3'd1, 1, 0, 0, 0, 0); checkOutput("branch_taken", pc, 32'h3100);

    jump_target = 32'h3400;
    applyStimulus(1, 3'd2, 0, 0, 0, 0, 0); checkOutput("stall_hold1", pc, 32'h3100);
    applyStimulus(1, 3'd0, 0, 0, 0, 0, 0); checkOutput("stall_hold2", pc, 32'h3100);
    applyStimulus(1, 3'd0, 0, 0, 0, 0, 0); checkOutput("stall_hold3", pc, 32'h3100);
    applyStimulus(0, 3'd0, 0, 0, 0, 0, 0); checkOutput("pending_applied", pc, 32'h3400);
    applyStimulus(0, 3'd0, 0, 0, 0, 0, 0); checkOutput("after_pending", pc, 32'h3404);

    jump_target = 32'h3500;
    applyStimulus(1, 3'd2, 0, 0, 0, 0, 0); checkOutput("stall_pend", pc, 32'h3404);
    applyStimulus(1, 3'd0, 0, 0, 0, 0, 1); checkOutput("exc_vector", pc, 32'h4180);
    applyStimulus(0, 3'd0, 0, 0, 0, 0, 0); checkOutput("exc_drops_pending", pc, 32'h4184);

    for (int i = 1; i <= 5; i++) applyStimulus(0, 3'd0, 0, 1, 32'(i * 16), 0, 0);
    checkOutput("ras_ovf_set", {31'h0, ras_overflow}, 32'h1);
    checkOutput("ras_top_50", ras_top, 32'h50);
    applyStimulus(0, 3'd0, 0, 0, 0, 1, 0); checkOutput("pop_40", ras_top, 32'h40);
    applyStimulus(0, 3'd0, 0, 0, 0, 1, 0); checkOutput("pop_30", ras_top, 32'h30);
    applyStimulus(0, 3'd0, 0, 0, 0, 1, 0); checkOutput("pop_20", ras_top, 32'h20);
    applyStimulus(0, 3'd0, 0, 0, 0, 1, 0);
    checkOutput("ras_drained", {31'h0, ras_empty}, 32'h1);

    jr_target = 32'h3800;
    applyStimulus(0, 3'd4, 0, 0, 0, 0, 0); checkOutput("ras_empty_jr", pc, 32'h3800);
    applyStimulus(0, 3'd0, 0, 1, 32'h3600, 0, 0);
    applyStimulus(0, 3'd4, 0, 0, 0, 0, 0); checkOutput("ras_predict", pc, 32'h3600);
    applyStimulus(0, 3'd0, 0, 1, 32'h3700, 1, 0);
    checkOutput("push_pop_top", ras_top, 32'h3700);
    checkOutput("push_pop_nonempty", {31'h0, ras_empty}, 32'h0);
    applyStimulus(0, 3'd0, 0, 0, 0, 1, 0);
    checkOutput("push_pop_count1", {31'h0, ras_empty}, 32'h1);

    for (int n = 0; n < 3000; n++) begin
      branch_target = $urandom() & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      jump_target   = $urandom() & 32'hFFFF_FFFC;
      jr_target     = $urandom() & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      link_addr     = $urandom();
      stall         = ($urandom_range(0, 3) == 0);
      pc_src        = 3'($urandom_range(0, 7));
      cmp           = 1'($urandom_range(0, 1));
      exc_req       = ($urandom_range(0, 29) == 0);
      link_push     = !exc_req && ($urandom_range(0, 3) == 0);
      ras_pop       = !exc_req && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        modelReset();
      end else begin
        reset = 1'b0;
      end
      step();
    end
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-PC generator with its own PC register, for the fetch stage of the pipelined MIPS core.
- Selects among the sequential, branch, jump, jr and return-stack-predicted targets.
- Holds a redirect that arrives while the pipeline is stalled, forces the exception vector, and keeps a small return-address stack (RAS) for jal/jr pairs.
- Drives the IM address and the F-stage PC.

Parameters:
WIDTH, 32, address width in bits
RESET_PC, 32'h0000_3000, PC value loaded on reset
EXC_VECTOR, 32'h0000_4180, PC value forced on exception
RAS_DEPTH, 4, number of return-stack entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC; the RAS does not update
pc_src  in  3  0 SEQ, 1 BRANCH, 2 JUMP, 3 JR, 4 RAS; 5-7 act as SEQ
cmp  in  1  branch condition; BRANCH is taken only when cmp=1
branch_target  in  WIDTH  branch destination
jump_target  in  WIDTH  j/jal destination
jr_target  in  WIDTH  register destination for jr
link_push  in  1  push link_addr onto the RAS (jal)
link_addr  in  WIDTH  return address to push (pc+8, delay slot)
ras_pop  in  1  pop the RAS (jr $ra retire)
exc_req  in  1  exception request
pc  out  WIDTH  current PC (registered)
pc_plus4  out  WIDTH  pc+4, combinational, wraps modulo 2^WIDTH
ras_top  out  WIDTH  top-of-stack entry; 0 when empty
ras_empty  out  1  RAS count is 0
ras_overflow  out  1  sticky; set by a push into a full stack
pc_misaligned  out  1  pc[1:0] != 0, combinational from pc

Behaviour:
- Reset (asynchronous): pc=RESET_PC, pending_valid=0, RAS count=0, RAS pointers=0, ras_overflow=0.
- Redirect target (combinational):
  - BRANCH&cmp gives branch_target; BRANCH&!cmp is not a redirect.
  - JUMP gives jump_target; JR gives jr_target.
  - RAS gives ras_top when not empty, else jr_target.
  - Any other code means no redirect.
- Next PC, in priority order:
  1. exc_req: pc<=EXC_VECTOR on the next edge regardless of stall; pending cleared.
  2. stall: pc holds. If a redirect is present, pending_target<=target and pending_valid<=1; a later redirect in the same stall overwrites it.
  3. !stall & pending_valid: pc<=pending_target and pending_valid<=0; the current pc_src is ignored this cycle.
  4. !stall & redirect: pc<=target.
  5. Otherwise pc<=pc_plus4.
- Latency: 1 cycle from select to pc. A pending redirect is applied on the first edge with stall=0.
- RAS is a circular buffer, updated only when !stall:
  - push only: write at top+1, count+1. If full, overwrite the oldest entry, count stays RAS_DEPTH, ras_overflow<=1.
  - pop only: count-1. Pop when empty has no effect.
  - push&pop together: top entry is replaced by link_addr, count unchanged. On an empty stack this acts as a push.
  - pc_src=RAS reads ras_top before that cycle's pop/push takes effect.
- exc_req does not alter the RAS.
- ras_overflow clears only on reset.
- No arithmetic saturation: pc+4 wraps.

Decomposition:
- Package pc_gen_pkg: pc_src encodings (PC_SEQ=0, PC_BRANCH=1, PC_JUMP=2, PC_JR=3, PC_RAS=4) and the default RESET_PC and EXC_VECTOR constants.
- One sub-module, pc_ras:
  - contains the circular stack with its push/pop/count/overflow logic, parametrised by WIDTH and RAS_DEPTH;
  - pc_gen instantiates it.

Test Plan:
- Reset, then 3 cycles with pc_src=0 -> pc reads 0x3000, 0x3004, 0x3008, 0x300C. Assert reset mid-run -> pc=0x3000 immediately, without waiting for a clock edge.
- pc=0x3010, pc_src=1, branch_target=0x3100: cmp=1 -> next pc 0x3100; cmp=0 -> next pc 0x3014.
- stall=1 for 3 cycles with pc_src=2, jump_target=0x3400 in cycle 1, then pc_src=0 -> pc holds for 3 cycles, then the first unstalled edge gives pc=0x3400, then 0x3404.
- exc_req=1 during stall with pending_valid=1 -> pc=0x4180 next edge, the pending redirect is discarded, then pc increments from 0x4184.
- RAS_DEPTH=4: push 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_overflow=1, ras_top=0x50. Then 4 pops expose 0x40, 0x30, 0x20 -> ras_empty=1.
- Empty RAS, pc_src=4, jr_target=0x3800 -> next pc 0x3800. Push 0x3600, then pc_src=4 -> next pc 0x3600. Push and pop together on [0x3600] -> top becomes link_addr, count stays 1.
